mem_stage: RTL
==============

# mem_stage

Memory stage of the MIPS pipeline, directly downstream of the execute stage. It consumes the ALU result, the forwarded register-B value and the destination register index. It performs byte, halfword and word loads and stores against an internal data memory, then registers everything into the MEM/WB pipeline register for write-back. A combinational debug read port exposes memory words to the debug unit.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width
- MEM_DEPTH, 32, data memory depth in 32-bit words (power of two)
- ADDR_BITS, $clog2(MEM_DEPTH), word-index width

Ports:
- i_clk  in  1  single clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_enable  in  1  pipeline advance (debug step/run); low freezes the stage
- i_aluresult  in  DATA_WIDTH  byte address for loads/stores, or a result to pass through
- i_regB  in  DATA_WIDTH  store data
- i_rd_rt  in  5  destination register index
- i_m  in  5  [4] memread, [3] memwrite, [2] unsigned load, [1:0] size (00 byte, 01 half, 11 word; 10 treated as word)
- i_wb  in  2  [1] regwrite, [0] memtoreg; passed through
- i_dbg_addr  in  ADDR_BITS  debug word index
- o_readdata  out  DATA_WIDTH  registered load data
- o_aluresult  out  DATA_WIDTH  registered pass-through
- o_rd_rt  out  5  registered pass-through
- o_wb  out  2  registered pass-through
- o_misaligned  out  1  registered flag: the access in the previous cycle was misaligned
- o_dbg_data  out  DATA_WIDTH  combinational memory word at i_dbg_addr

## Operation
- Word index = i_aluresult[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*MEM_DEPTH. Byte lane = i_aluresult[1:0], little-endian (lane 0 = bits 7:0).
- Alignment rules: a word access needs addr[1:0]==0, a half access needs addr[0]==0, a byte access is always aligned.
- Store (memwrite=1, aligned): write only the addressed lanes. Byte writes i_regB[7:0] to the lane. Half writes i_regB[15:0] to lanes {addr[1],0}/{addr[1],1}. Word writes all 4 lanes.
- Load (memread=1, aligned): extract the lane(s). Sign-extend from bit 7/15 unless unsigned=1, in which case zero-extend. A word load ignores unsigned.
- Misaligned access: the write is suppressed, o_readdata = 0, and o_misaligned = 1 for that registered cycle.
- No memread: o_readdata = 0.
- memread and memwrite both 1: the store is performed. o_readdata returns the pre-store word contents, extracted per size.
- i_enable=0: no memory write, and all output registers hold. The debug port still reads.

## Timing
- Memory write commits on the rising edge where i_enable=1.
- Read is combinational from the array and captured in the MEM/WB register. Outputs reflect the inputs presented in the previous enabled cycle, so latency is 1 cycle.
- A store in cycle N followed by a load of the same address in cycle N+1 returns the new data.
- o_dbg_data reflects a write on the same edge the write commits.
- Reset (async, i_reset=0): all outputs go to 0 immediately and every memory word is cleared to 0. Reset asserted mid-store aborts the write. Release is synchronous to the next edge.

## Structure
- Package mips_mem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - i_m bit indices M_READ/M_WRITE/M_UNSIGNED
  - i_wb bit indices WB_REGWRITE/WB_MEMTOREG
- Sub-module data_memory owns the word array, per-lane write enables, async clear and the two combinational read ports (pipeline and debug). mem_stage itself holds the alignment check, lane steering, load extension and the MEM/WB register.

## Test plan
- Reset: drive i_reset=0 mid-operation -> all outputs 0 at once, and o_dbg_data=0 for every index.
- Word store 0xDEADBEEF at addr 0x8, then word load 0x8 -> o_readdata=0xDEADBEEF one cycle after the load; o_dbg_data at index 2 = 0xDEADBEEF.
- Byte store 0x80 at addr 0x9 over 0x00000000, then signed byte load 0x9 -> 0xFFFFFF80; unsigned byte load -> 0x00000080; word at index 2 = 0x00008000.
- Half store 0x1234 at addr 0x3 (misaligned) -> memory unchanged and o_misaligned=1; a half load at 0x3 -> o_readdata=0.
- Address 0x80 with MEM_DEPTH=32 wraps to index 0; storing 0x11 there and loading word 0x0 -> 0x00000011.
- With i_enable=0, a store to 0x4 is presented -> memory and outputs unchanged; after raising i_enable the store takes effect.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared encodings for the MIPS memory stage
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam int M_READ     = 4;
  localparam int M_WRITE    = 3;
  localparam int M_UNSIGNED = 2;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

  // Size 2'b10 falls into the word case.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return |lane;
    endcase
  endfunction

endpackage

// File: rtl/data_memory.sv
// rtl/data_memory.sv - word array with per-lane write enables, async clear,
// and combinational pipeline and debug read ports
module data_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_BITS  = $clog2(MEM_DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_we,
  input  logic [ADDR_BITS-1:0]      i_addr,
  input  logic [DATA_WIDTH/8-1:0]   i_be,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  logic [ADDR_BITS-1:0]      i_dbg_addr,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic [DATA_WIDTH-1:0]     o_dbg_data
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int w = 0; w < MEM_DEPTH; w++) begin
        r_mem[w] <= '0;
      end
    end else if (i_we) begin
      for (int l = 0; l < LANES; l++) begin
        if (i_be[l]) begin
          r_mem[i_addr][8*l +: 8] <= i_wdata[8*l +: 8];
        end
      end
    end
  end

  assign o_rdata    = r_mem[i_addr];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: alignment check, lane steering,
// load extension and the MEM/WB pipeline register
module mem_stage
  import mips_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 32,
  parameter int ADDR_BITS  = $clog2(MEM_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic [DATA_WIDTH-1:0] i_aluresult,
  input  logic [DATA_WIDTH-1:0] i_regB,
  input  logic [4:0]            i_rd_rt,
  input  logic [4:0]            i_m,
  input  logic [1:0]            i_wb,
  input  logic [ADDR_BITS-1:0]  i_dbg_addr,
  output logic [DATA_WIDTH-1:0] o_readdata,
  output logic [DATA_WIDTH-1:0] o_aluresult,
  output logic [4:0]            o_rd_rt,
  output logic [1:0]            o_wb,
  output logic                  o_misaligned,
  output logic [DATA_WIDTH-1:0] o_dbg_data
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [ADDR_BITS-1:0]  w_idx;
  logic [1:0]            w_lane;
  logic [1:0]            w_size;
  logic                  w_read;
  logic                  w_write;
  logic                  w_unsigned;
  logic                  w_mis;
  logic                  w_we;
  logic [LANES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_load;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_unused;

  // Addresses wrap: bits above the word index are deliberately dropped.
  assign w_idx      = i_aluresult[ADDR_BITS+1:2];
  assign w_lane     = i_aluresult[1:0];
  assign w_unused   = ^i_aluresult[DATA_WIDTH-1:ADDR_BITS+2];
  assign w_size     = i_m[1:0];
  assign w_read     = i_m[M_READ];
  assign w_write    = i_m[M_WRITE];
  assign w_unsigned = i_m[M_UNSIGNED];
  assign w_mis      = (w_read | w_write) & is_misaligned(w_size, w_lane);
  assign w_we       = i_enable & w_write & ~w_mis;

  always_comb begin
    w_be    = '1;
    w_wdata = i_regB;
    case (w_size)
      SZ_BYTE: begin
        w_be    = {{(LANES-1){1'b0}}, 1'b1} << w_lane;
        w_wdata = {LANES{i_regB[7:0]}};
      end
      SZ_HALF: begin
        w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
        w_wdata = {(LANES/2){i_regB[15:0]}};
      end
      default: ;
    endcase
  end

  data_memory #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_data_memory (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we      (w_we),
    .i_addr    (w_idx),
    .i_be      (w_be),
    .i_wdata   (w_wdata),
    .i_dbg_addr(i_dbg_addr),
    .o_rdata   (w_rdata),
    .o_dbg_data(o_dbg_data)
  );

  // The read port sees the pre-store word, so read+write returns old contents.
  assign w_byte = w_rdata[{w_lane, 3'b000} +: 8];
  assign w_half = w_rdata[{w_lane[1], 4'b0000} +: 16];

  always_comb begin
    w_load = '0;
    if (w_read && !w_mis) begin
      case (w_size)
        SZ_BYTE: w_load = {{(DATA_WIDTH-8){w_byte[7] & ~w_unsigned}}, w_byte};
        SZ_HALF: w_load = {{(DATA_WIDTH-16){w_half[15] & ~w_unsigned}}, w_half};
        default: w_load = w_rdata;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_readdata   <= '0;
      o_aluresult  <= '0;
      o_rd_rt      <= '0;
      o_wb         <= '0;
      o_misaligned <= 1'b0;
    end else if (i_enable) begin
      o_readdata   <= w_load;
      o_aluresult  <= i_aluresult;
      o_rd_rt      <= i_rd_rt;
      o_wb         <= {i_wb[WB_REGWRITE], i_wb[WB_MEMTOREG]};
      o_misaligned <= w_mis | (w_unused & 1'b0);
    end
  end

endmodule
